// File: rtl/fifo_pkg.sv
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared mode constants and sizing helper for the programmable FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
//  Module   : fifo_mem
//  Purpose  : 1-write / 1-read storage array, synchronous write, async read.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int c_AW  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [c_AW-1:0]   i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [c_AW-1:0]   i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    // No reset: contents are meaningless until written through the pointers.
    logic [WIDTH-1:0] r_mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem_q[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_prog.sv
// ============================================================================
//  Module   : fifo_prog
//  Purpose  : Synchronous FIFO with programmable thresholds, std or FWFT read.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_prog
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    parameter  int FWFT       = 0,
    localparam int c_CW       = calc_cw(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [c_CW-1:0]       af_thresh,
    input  logic [c_CW-1:0]       ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic [c_CW-1:0]       count,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);

    localparam int              c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);
    localparam logic [c_AW-1:0] c_LAST  = c_AW'(FIFO_DEPTH - 1);

    logic [c_AW-1:0]       r_wr_ptr_q, w_wr_ptr_d;
    logic [c_AW-1:0]       r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CW-1:0]       r_count_q,  w_count_d;
    logic                  r_wr_ack_q, w_wr_ack_d;
    logic                  r_overflow_q, w_overflow_d;
    logic                  r_underflow_q, w_underflow_d;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_mem_we;
    logic [FIFO_WIDTH-1:0] w_mem_rdata;

    always_comb begin
        // A full FIFO still takes a write when a read frees the slot this cycle.
        w_wr_accept   = wr_en && ((r_count_q < c_DEPTH) ||
                                  (rd_en && (r_count_q == c_DEPTH)));
        w_rd_accept   = rd_en && (r_count_q != '0);

        w_wr_ptr_d    = r_wr_ptr_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_count_d     = r_count_q;

        if (w_wr_accept) begin
            w_wr_ptr_d = (r_wr_ptr_q == c_LAST) ? '0 : r_wr_ptr_q + c_AW'(1);
        end
        if (w_rd_accept) begin
            w_rd_ptr_d = (r_rd_ptr_q == c_LAST) ? '0 : r_rd_ptr_q + c_AW'(1);
        end

        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_d = r_count_q + c_CW'(1);
            2'b01:   w_count_d = r_count_q - c_CW'(1);
            default: w_count_d = r_count_q;
        endcase

        w_wr_ack_d    = w_wr_accept;
        w_overflow_d  = wr_en && !w_wr_accept;
        w_underflow_d = rd_en && !w_rd_accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_count_q     <= '0;
            r_wr_ack_q    <= 1'b0;
            r_overflow_q  <= 1'b0;
            r_underflow_q <= 1'b0;
        end else begin
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_count_q     <= w_count_d;
            r_wr_ack_q    <= w_wr_ack_d;
            r_overflow_q  <= w_overflow_d;
            r_underflow_q <= w_underflow_d;
        end
    end

    assign w_mem_we = w_wr_accept && !rst;

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr_q),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr_q),
        .o_rdata (w_mem_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign data_out = (r_count_q != '0) ? w_mem_rdata : '0;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] r_dout_q, w_dout_d;

            always_comb begin
                w_dout_d = r_dout_q;
                if (w_rd_accept) begin
                    w_dout_d = w_mem_rdata;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout_q <= '0;
                end else begin
                    r_dout_q <= w_dout_d;
                end
            end

            assign data_out = r_dout_q;
        end
    endgenerate

    assign count       = r_count_q;
    assign wr_ack      = r_wr_ack_q;
    assign overflow    = r_overflow_q;
    assign underflow   = r_underflow_q;
    assign full        = (r_count_q == c_DEPTH);
    assign empty       = (r_count_q == '0);
    assign almostfull  = (r_count_q >= af_thresh);
    assign almostempty = (r_count_q <= ae_thresh);

endmodule

`default_nettype wire

// File: tb/tb_fifo_prog.sv
// ============================================================================
//  Module   : tb_fifo_prog
//  Purpose  : Scoreboard bench for fifo_prog (std/8, FWFT/8, std/5 instances).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_prog;

    typedef struct packed {
        logic [15:0] dout;
        logic [10:0] count;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic        wr_ack;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  af8 = '0, ae8 = '0;
    logic [2:0]  af5 = '0, ae5 = '0;
    logic [3:0]  nxt_af8 = 4'd6, nxt_ae8 = 4'd2;
    logic [2:0]  nxt_af5 = 3'd4, nxt_ae5 = 3'd1;

    logic [15:0] dout_a, dout_b, dout_c;
    logic [3:0]  cnt_a, cnt_b;
    logic [2:0]  cnt_c;
    logic        ack_a, ovf_a, unf_a, full_a, empty_a, af_a, ae_a;
    logic        ack_b, ovf_b, unf_b, full_b, empty_b, af_b, ae_b;
    logic        ack_c, ovf_c, unf_c, full_c, empty_c, af_c, ae_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_std8 (
        .clk(clk), .rst(rst), .data_in(din), .wr_en(wr_en), .rd_en(rd_en),
        .af_thresh(af8), .ae_thresh(ae8), .data_out(dout_a), .count(cnt_a),
        .wr_ack(ack_a), .overflow(ovf_a), .underflow(unf_a), .full(full_a),
        .empty(empty_a), .almostfull(af_a), .almostempty(ae_a));

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_fwft8 (
        .clk(clk), .rst(rst), .data_in(din), .wr_en(wr_en), .rd_en(rd_en),
        .af_thresh(af8), .ae_thresh(ae8), .data_out(dout_b), .count(cnt_b),
        .wr_ack(ack_b), .overflow(ovf_b), .underflow(unf_b), .full(full_b),
        .empty(empty_b), .almostfull(af_b), .almostempty(ae_b));

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_std5 (
        .clk(clk), .rst(rst), .data_in(din), .wr_en(wr_en), .rd_en(rd_en),
        .af_thresh(af5), .ae_thresh(ae5), .data_out(dout_c), .count(cnt_c),
        .wr_ack(ack_c), .overflow(ovf_c), .underflow(unf_c), .full(full_c),
        .empty(empty_c), .almostfull(af_c), .almostempty(ae_c));

    // Reference model: one word queue per instance plus the std-mode output latch.
    logic [15:0] mq [3][$];
    logic [15:0] mdout [3];
    exp_t        sb [3][$];
    int          c_dep [3] = '{8, 8, 5};
    bit          c_fw  [3] = '{1'b0, 1'b1, 1'b0};

    task automatic model_step(input int k);
        exp_t        e;
        int          n, af, ae;
        bit          wa, ra;
        logic [15:0] v;
        e = '0;
        if (rst) begin
            mq[k].delete();
            mdout[k] = '0;
        end else begin
            n  = mq[k].size();
            wa = wr_en && (n < c_dep[k] || (rd_en && n == c_dep[k]));
            ra = rd_en && (n > 0);
            if (ra) begin
                v = mq[k].pop_front();
                if (!c_fw[k]) mdout[k] = v;
            end
            if (wa) mq[k].push_back(din);
            e.wr_ack = wa;
            e.ovf    = wr_en && !wa;
            e.unf    = rd_en && !ra;
        end
        n       = mq[k].size();
        af      = (k == 2) ? int'(af5) : int'(af8);
        ae      = (k == 2) ? int'(ae5) : int'(ae8);
        e.count = 11'(n);
        e.full  = (n == c_dep[k]);
        e.empty = (n == 0);
        e.af    = (n >= af);
        e.ae    = (n <= ae);
        if (c_fw[k]) e.dout = (n > 0) ? mq[k][0] : 16'h0;
        else         e.dout = mdout[k];
        sb[k].push_back(e);
    endtask

    task automatic step(input bit r, input bit w, input bit rd, input logic [15:0] d);
        @(posedge clk);
        #3;
        rst = r; wr_en = w; rd_en = rd; din = d;
        af8 = nxt_af8; ae8 = nxt_ae8; af5 = nxt_af5; ae5 = nxt_ae5;
        for (int k = 0; k < 3; k++) model_step(k);
    endtask

    function automatic exp_t actual(input int k);
        exp_t a;
        a = '0;
        case (k)
            0: a = '{dout_a, 11'(cnt_a), full_a, empty_a, af_a, ae_a, ack_a, ovf_a, unf_a};
            1: a = '{dout_b, 11'(cnt_b), full_b, empty_b, af_b, ae_b, ack_b, ovf_b, unf_b};
            default: a = '{dout_c, 11'(cnt_c), full_c, empty_c, af_c, ae_c, ack_c, ovf_c, unf_c};
        endcase
        return a;
    endfunction

    task automatic chk(input string name, input int k, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, k, $time, act, req);
        end
    endtask

    // Monitor: compares one expectation per instance, 1ns after each edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (sb[k].size() > 0) begin
                    e = sb[k].pop_front();
                    a = actual(k);
                    chk("data_out",    k, int'(a.dout),   int'(e.dout));
                    chk("count",       k, int'(a.count),  int'(e.count));
                    chk("full",        k, int'(a.full),   int'(e.full));
                    chk("empty",       k, int'(a.empty),  int'(e.empty));
                    chk("almostfull",  k, int'(a.af),     int'(e.af));
                    chk("almostempty", k, int'(a.ae),     int'(e.ae));
                    chk("wr_ack",      k, int'(a.wr_ack), int'(e.wr_ack));
                    chk("overflow",    k, int'(a.ovf),    int'(e.ovf));
                    chk("underflow",   k, int'(a.unf),    int'(e.unf));
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 16'h0);
        step(1, 1, 1, 16'hFFFF);

        // Fill past full, then drain past empty.
        for (int i = 1; i <= 9; i++) step(0, 1, 0, 16'(i));
        for (int i = 0; i < 9; i++)  step(0, 0, 1, 16'h0);

        // Full with simultaneous write and read.
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 16'(i));
        step(0, 1, 1, 16'hAAAA);
        for (int i = 0; i < 9; i++)  step(0, 0, 1, 16'h0);

        // Empty with simultaneous write and read.
        step(0, 1, 1, 16'h1234);
        step(0, 0, 0, 16'h0);
        step(0, 0, 1, 16'h0);

        // Pointer wrap through repeated fill/drain cycles.
        for (int i = 0; i < 12; i++) step(0, 1, 0, 16'h0100 + 16'(i));
        for (int i = 0; i < 12; i++) step(0, 0, 1, 16'h0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 16'h0200 + 16'(i));
            step(0, 0, 1, 16'h0);
        end

        // Reset mid-operation with a pending write.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h0300 + 16'(i));
        step(1, 1, 0, 16'h5555);
        step(0, 0, 0, 16'h0);
        step(0, 0, 1, 16'h0);

        // Thresholds beyond depth.
        nxt_af8 = 4'd12; nxt_ae8 = 4'd10; nxt_af5 = 3'd7; nxt_ae5 = 3'd6;
        for (int i = 0; i < 10; i++) step(0, 1, 0, 16'h0400 + 16'(i));
        for (int i = 0; i < 10; i++) step(0, 0, 1, 16'h0);

        // Randomised traffic with occasional threshold changes and resets.
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                nxt_af8 = 4'($urandom_range(0, 15));
                nxt_ae8 = 4'($urandom_range(0, 15));
                nxt_af5 = 3'($urandom_range(0, 7));
                nxt_ae5 = 3'($urandom_range(0, 7));
            end
            step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 16'($urandom));
        end

        step(0, 0, 0, 16'h0);
        @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) chk("scoreboard_drained", k, sb[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
